// File: rtl/demux_router.sv
// demux_router: steers a muxed word stream into two FIFOs with a one-entry hold for almost-full targets
module demux_router #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  dest_in,
  output logic                  ready_out,
  input  logic                  almost_full0,
  input  logic                  almost_full1,
  output logic                  push_0,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic                  push_1,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [CNT_WIDTH-1:0]  count0,
  output logic [CNT_WIDTH-1:0]  count1,
  output logic                  holding
);
  typedef enum logic {PASS, HOLD} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_dest;
  logic                  w_dest;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_af;
  logic                  go;
  assign holding   = (state == HOLD);
  assign ready_out = ~holding;
  // pick the word in play this cycle: the held word takes precedence over upstream
  always_comb begin
    w_dest = holding ? hold_dest : dest_in;
    w_data = holding ? hold_data : data_in;
    w_af   = w_dest ? almost_full1 : almost_full0;
    go     = (holding | valid_in) & ~w_af;
  end
  // push/count registers plus the PASS/HOLD sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PASS;
      hold_data <= '0;
      hold_dest <= 1'b0;
      push_0    <= 1'b0;
      push_1    <= 1'b0;
      data_out0 <= '0;
      data_out1 <= '0;
      count0    <= '0;
      count1    <= '0;
    end else begin
      push_0 <= go & ~w_dest;
      push_1 <= go & w_dest;
      if (go & ~w_dest) begin
        data_out0 <= w_data;
        count0    <= count0 + CNT_WIDTH'(1);
      end
      if (go & w_dest) begin
        data_out1 <= w_data;
        count1    <= count1 + CNT_WIDTH'(1);
      end
      if (!holding && valid_in && w_af) begin
        hold_data <= data_in;
        hold_dest <= dest_in;
        state     <= HOLD;
      end else if (holding && !w_af) begin
        state <= PASS;
      end
    end
  end
endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: vector table, directed corner sequences and random traffic against a queue model
module tb_demux_router;
  localparam int DW = 8;
  localparam int CW = 4;
  logic          clk = 0;
  logic          reset = 1;
  logic          valid_in = 0;
  logic [DW-1:0] data_in = '0;
  logic          dest_in = 0;
  logic          almost_full0 = 0;
  logic          almost_full1 = 0;
  logic          ready_out, push_0, push_1, holding;
  logic [DW-1:0] data_out0, data_out1;
  logic [CW-1:0] count0, count1;
  int checks = 0;
  int errors = 0;
  demux_router #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .dest_in(dest_in),
    .ready_out(ready_out), .almost_full0(almost_full0), .almost_full1(almost_full1),
    .push_0(push_0), .data_out0(data_out0), .push_1(push_1), .data_out1(data_out1),
    .count0(count0), .count1(count1), .holding(holding)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic          dst;
    logic [DW-1:0] d;
  } word_t;
  word_t   mq[$];
  logic    m_p0 = 0, m_p1 = 0;
  logic [DW-1:0] m_d0 = 0, m_d1 = 0;
  int      m_c0 = 0, m_c1 = 0;
  typedef struct {
    logic          rst, v, dst, af0, af1;
    logic [DW-1:0] d;
    logic          ep0, ep1;
    logic [DW-1:0] ed;
    logic          eh;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic deliver(input word_t w);
    if (w.dst) begin m_p1 = 1; m_d1 = w.d; m_c1 = (m_c1 + 1) % (1 << CW); end
    else begin m_p0 = 1; m_d0 = w.d; m_c0 = (m_c0 + 1) % (1 << CW); end
  endtask
  task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic dst,
                      input logic a0, input logic a1);
    logic af[2];
    word_t w;
    reset = r; valid_in = v; data_in = d; dest_in = dst; almost_full0 = a0; almost_full1 = a1;
    #1;
    chk("ready_out", ready_out, mq.size() == 0);
    @(posedge clk);
    af[0] = a0; af[1] = a1;
    m_p0 = 0; m_p1 = 0;
    if (r) begin
      mq.delete(); m_d0 = 0; m_d1 = 0; m_c0 = 0; m_c1 = 0;
    end else if (mq.size() != 0) begin
      if (!af[mq[0].dst]) deliver(mq.pop_front());
    end else if (v) begin
      w.dst = dst; w.d = d;
      if (af[dst]) mq.push_back(w); else deliver(w);
    end
    #1;
    chk("push_0", push_0, m_p0);
    chk("push_1", push_1, m_p1);
    chk("data_out0", data_out0, m_d0);
    chk("data_out1", data_out1, m_d1);
    chk("count0", count0, m_c0);
    chk("count1", count1, m_c1);
    chk("holding", holding, mq.size() != 0);
    chk("one_hot", push_0 & push_1, 0);
  endtask
  task automatic add(input logic r, v, input logic [DW-1:0] d, input logic dst, a0, a1,
                     input logic ep0, ep1, input logic [DW-1:0] ed, input logic eh);
    vec_t t;
    t = '{r, v, dst, a0, a1, d, ep0, ep1, ed, eh};
    tv.push_back(t);
  endtask
  initial begin
    logic [DW-1:0] s0, s1;
    add(1,0,8'h00,0,0,0, 0,0,8'h00,0);
    add(0,1,8'h11,0,0,0, 1,0,8'h11,0);
    add(0,1,8'h22,1,0,0, 0,1,8'h22,0);
    add(0,1,8'h33,0,0,0, 1,0,8'h33,0);
    add(0,1,8'h44,1,0,0, 0,1,8'h44,0);
    add(0,0,8'h00,0,0,0, 0,0,8'h00,0);
    add(0,1,8'hA5,0,1,0, 0,0,8'h00,1);
    add(0,1,8'hA5,0,1,0, 0,0,8'h00,1);
    add(0,1,8'hA5,0,1,0, 0,0,8'h00,1);
    add(0,0,8'h00,0,0,0, 1,0,8'hA5,0);
    add(0,0,8'h00,0,0,0, 0,0,8'h00,0);
    for (int i = 1; i <= 4; i++) add(0,1,DW'(i),0,0,1, 1,0,DW'(i),0);
    add(0,1,8'h55,1,0,1, 0,0,8'h00,1);
    add(0,1,8'h06,0,0,1, 0,0,8'h00,1);
    add(0,0,8'h00,0,0,0, 0,1,8'h55,0);
    add(0,1,8'h06,0,0,0, 1,0,8'h06,0);
    add(0,1,8'h7E,1,0,1, 0,0,8'h00,1);
    add(1,0,8'h00,0,0,1, 0,0,8'h00,0);
    add(0,0,8'h00,0,0,0, 0,0,8'h00,0);
    add(0,0,8'h00,0,0,0, 0,0,8'h00,0);
    @(posedge clk); #1;
    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].v, tv[i].d, tv[i].dst, tv[i].af0, tv[i].af1);
      chk("tv_push_0", push_0, tv[i].ep0);
      chk("tv_push_1", push_1, tv[i].ep1);
      chk("tv_holding", holding, tv[i].eh);
      if (tv[i].ep0) chk("tv_data0", data_out0, tv[i].ed);
      if (tv[i].ep1) chk("tv_data1", data_out1, tv[i].ed);
    end
    chk("post_reset_count0", count0, 0);
    chk("post_reset_count1", count1, 0);
    for (int i = 1; i <= 17; i++) begin
      step(0, 1, DW'(i), 0, 0, 0);
      chk("wrap_count0", count0, i % 16);
    end
    step(0, 1, 8'hC3, 1, 0, 0);
    s0 = data_out0; s1 = data_out1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, DW'($urandom), 1'($urandom), 0, 0);
      chk("idle_d0", data_out0, s0);
      chk("idle_d1", data_out1, s1);
      chk("idle_c0", count0, 1);
      chk("idle_c1", count1, 1);
    end
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, DW'($urandom), 1'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
